// File: rtl/gpio_defaults_pkg.sv
// gpio_defaults_pkg
// Shared definitions for the GPIO defaults loader:
//   - gpio_state_e                 : loader FSM state encoding
//   - CFG_WIDTH_DEFAULT            : width of one pad configuration word
//   - GPIO_CFG_USER_INPUT_NOPULL   : power-on word (user input, no pull)
package gpio_defaults_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } gpio_state_e;

    localparam int          CFG_WIDTH_DEFAULT          = 13;
    localparam logic [12:0] GPIO_CFG_USER_INPUT_NOPULL = 13'h0402;

endpackage

// File: rtl/gpio_defaults_loader_shifter.sv
// gpio_serial_shifter
// Phase/bit/channel counters and serial_clock/serial_data generation for the
// GPIO defaults chain. Channel NUM_GPIO-1 goes out first, each word MSB first.
// Every bit spends CLK_DIV cycles with serial_clock low, then CLK_DIV cycles
// with serial_clock high, with serial_data held across both phases.
//
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   init          : preload counters for a new stream (issued from IDLE)
//   active        : phase counter runs (SHIFT or LOAD)
//   shifting      : bit/channel counters advance and serial outputs are live
//   words         : flat configuration words, channel i at [i*CFG_WIDTH +: CFG_WIDTH]
//   serial_clock  : chain shift clock
//   serial_data   : chain shift data
//   phase_last    : phase counter is in the last cycle of its phase
//   shift_last    : final cycle of the final bit of the stream
module gpio_serial_shifter #(
    parameter int NUM_GPIO  = 38,
    parameter int CFG_WIDTH = 13,
    parameter int CLK_DIV   = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          init,
    input  logic                          active,
    input  logic                          shifting,
    input  logic [NUM_GPIO*CFG_WIDTH-1:0] words,
    output logic                          serial_clock,
    output logic                          serial_data,
    output logic                          phase_last,
    output logic                          shift_last
);

    localparam int PH_W  = $clog2(CLK_DIV + 1);
    localparam int BIT_W = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
    localparam int CH_W  = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;

    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(CFG_WIDTH - 1);
    localparam logic [CH_W-1:0]  CH_TOP  = CH_W'(NUM_GPIO - 1);

    logic [PH_W-1:0]      phase_cnt;
    logic                 high_q;      // 0: serial_clock low phase, 1: high phase
    logic [BIT_W-1:0]     bit_cnt;
    logic [CH_W-1:0]      ch_cnt;
    logic [CFG_WIDTH-1:0] word;
    logic                 bit_done;

    assign phase_last = (phase_cnt == PH_LAST);
    assign bit_done   = shifting && phase_last && high_q;
    assign shift_last = bit_done && (bit_cnt == '0) && (ch_cnt == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_cnt <= '0;
            high_q    <= 1'b0;
            bit_cnt   <= '0;
            ch_cnt    <= '0;
        end else if (init) begin
            phase_cnt <= '0;
            high_q    <= 1'b0;
            bit_cnt   <= BIT_TOP;
            ch_cnt    <= CH_TOP;
        end else if (active) begin
            // The phase counter also times the LOAD strobe, so it keeps
            // running outside SHIFT.
            phase_cnt <= phase_last ? '0 : phase_cnt + PH_W'(1);
            if (shifting && phase_last) begin
                high_q <= !high_q;
                if (high_q) begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - BIT_W'(1);
                    end else if (ch_cnt != '0) begin
                        bit_cnt <= BIT_TOP;
                        ch_cnt  <= ch_cnt - CH_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        word = '0;
        for (int c = 0; c < NUM_GPIO; c++) begin
            if (ch_cnt == CH_W'(c)) begin
                word = words[c*CFG_WIDTH +: CFG_WIDTH];
            end
        end
    end

    assign serial_clock = shifting && high_q;
    assign serial_data  = shifting && word[bit_cnt];

endmodule

// File: rtl/gpio_defaults_loader.sv
// gpio_defaults_loader
// Holds the power-on configuration words of NUM_GPIO pads and shifts them
// serially into the gpio_control_block chain, followed by a latch strobe.
// Words can be overridden at runtime through a single-word write port.
//
// Build option: GPIO_DEFAULTS_AUTOLOAD_EN -- when defined, the first cycle
// after resetn deasserts acts as an internal start (once per reset release).
//
// Ports:
//   clk, resetn    : clock, asynchronous active-low reset
//   start          : request a full chain load (honoured in IDLE only)
//   busy           : high in SHIFT and LOAD
//   done           : one-cycle pulse when a load completes
//   serial_clock   : chain shift clock
//   serial_data    : chain shift data
//   serial_load    : chain latch strobe
//   ovr_we         : override write request
//   ovr_idx        : override target channel
//   ovr_data       : override word
//   ovr_ack        : one-cycle write acknowledge
//   ovr_err        : pulses with ovr_ack when ovr_idx is out of range
//   gpio_defaults  : current stored words, flat
module gpio_defaults_loader
    import gpio_defaults_pkg::*;
#(
    parameter int NUM_GPIO  = 38,
    parameter int CFG_WIDTH = CFG_WIDTH_DEFAULT,
    parameter logic [NUM_GPIO*CFG_WIDTH-1:0] GPIO_CONFIG_INIT =
        {NUM_GPIO{CFG_WIDTH'(GPIO_CFG_USER_INPUT_NOPULL)}},
    parameter int CLK_DIV   = 2,
    localparam int IDX_W    = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          serial_clock,
    output logic                          serial_data,
    output logic                          serial_load,
    input  logic                          ovr_we,
    input  logic [IDX_W-1:0]              ovr_idx,
    input  logic [CFG_WIDTH-1:0]          ovr_data,
    output logic                          ovr_ack,
    output logic                          ovr_err,
    output logic [NUM_GPIO*CFG_WIDTH-1:0] gpio_defaults
);

    // Loader FSM state; kept as a named signal so checkers can bind to it.
    gpio_state_e state_q, state_d;

    logic [NUM_GPIO*CFG_WIDTH-1:0] defaults_q;
    logic ovr_ack_q, ovr_err_q;
    logic start_eff;
    logic shift_init;
    logic ovr_accept, ovr_bad;
    logic sh_active, sh_shifting, sh_phase_last, sh_shift_last;

`ifdef GPIO_DEFAULTS_AUTOLOAD_EN
    // High only in the first cycle after reset release.
    logic autoload_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) autoload_q <= 1'b1;
        else         autoload_q <= 1'b0;
    end
    assign start_eff = start | autoload_q;
`else
    assign start_eff = start;
`endif

    // Override handshake: the requester raises ovr_we with ovr_idx/ovr_data
    // and holds all three until ovr_ack. A write is taken only in IDLE; the
    // cycle carrying ovr_ack never takes another, so a held request that the
    // requester drops on seeing the ack commits exactly once.
    assign ovr_bad    = ({1'b0, ovr_idx} >= (IDX_W + 1)'(NUM_GPIO));
    assign ovr_accept = ovr_we && (state_q == IDLE) && !ovr_ack_q;

    // Writes are only taken in IDLE, so the stored words cannot move while a
    // stream is in flight; a write coinciding with start lands first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            defaults_q <= GPIO_CONFIG_INIT;
        end else if (ovr_accept && !ovr_bad) begin
            for (int i = 0; i < NUM_GPIO; i++) begin
                if (ovr_idx == IDX_W'(i)) begin
                    defaults_q[i*CFG_WIDTH +: CFG_WIDTH] <= ovr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovr_ack_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            ovr_ack_q <= ovr_accept;
            ovr_err_q <= ovr_accept && ovr_bad;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_eff)     state_d = SHIFT;
            SHIFT:   if (sh_shift_last) state_d = LOAD;
            LOAD:    if (sh_phase_last) state_d = DONE;
            DONE:                       state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    assign shift_init  = (state_q == IDLE) && start_eff;
    assign sh_active   = (state_q == SHIFT) || (state_q == LOAD);
    assign sh_shifting = (state_q == SHIFT);

    gpio_serial_shifter #(
        .NUM_GPIO  (NUM_GPIO),
        .CFG_WIDTH (CFG_WIDTH),
        .CLK_DIV   (CLK_DIV)
    ) u_shifter (
        .clk          (clk),
        .resetn       (resetn),
        .init         (shift_init),
        .active       (sh_active),
        .shifting     (sh_shifting),
        .words        (defaults_q),
        .serial_clock (serial_clock),
        .serial_data  (serial_data),
        .phase_last   (sh_phase_last),
        .shift_last   (sh_shift_last)
    );

    // Outputs decode directly from state so an asynchronous reset clears
    // them immediately and never lets a partial chain latch.
    assign busy          = sh_active;
    assign done          = (state_q == DONE);
    assign serial_load   = (state_q == LOAD);
    assign ovr_ack       = ovr_ack_q;
    assign ovr_err       = ovr_err_q;
    assign gpio_defaults = defaults_q;

endmodule

// File: tb/tb_gpio_defaults_loader.sv
`timescale 1ns/1ps
module tb_gpio_defaults_loader;

    localparam int NUM_GPIO  = 3;
    localparam int CFG_WIDTH = 4;
    localparam int CLK_DIV   = 2;
    localparam int IDX_W     = $clog2(NUM_GPIO);
    localparam int FLAT_W    = NUM_GPIO * CFG_WIDTH;
    localparam logic [FLAT_W-1:0] INIT = 12'h5A3;
    localparam int SHIFT_CYC = FLAT_W * 2 * CLK_DIV;
    localparam int VEC_W     = 7;
    localparam int ACK_IDX   = SHIFT_CYC + CLK_DIV + 2; // IDLE cycle carrying a stalled ack

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic ovr_we = 1'b0;
    logic [IDX_W-1:0] ovr_idx = '0;
    logic [CFG_WIDTH-1:0] ovr_data = '0;
    logic busy, done, serial_clock, serial_data, serial_load, ovr_ack, ovr_err;
    logic [FLAT_W-1:0] gpio_defaults;

    always #5 clk = ~clk;

    gpio_defaults_loader #(
        .NUM_GPIO         (NUM_GPIO),
        .CFG_WIDTH        (CFG_WIDTH),
        .GPIO_CONFIG_INIT (INIT),
        .CLK_DIV          (CLK_DIV)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .serial_clock  (serial_clock),
        .serial_data   (serial_data),
        .serial_load   (serial_load),
        .ovr_we        (ovr_we),
        .ovr_idx       (ovr_idx),
        .ovr_data      (ovr_data),
        .ovr_ack       (ovr_ack),
        .ovr_err       (ovr_err),
        .gpio_defaults (gpio_defaults)
    );

    // ---------------- scoreboard / model ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [VEC_W-1:0] exp_q[$];
    logic [CFG_WIDTH-1:0] model_mem [NUM_GPIO];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {busy, serial_clock, serial_data, serial_load, done, ovr_ack, ovr_err}
    function automatic logic [VEC_W-1:0] obs();
        return {busy, serial_clock, serial_data, serial_load, done, ovr_ack, ovr_err};
    endfunction

    function automatic logic [FLAT_W-1:0] model_flat();
        logic [FLAT_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_GPIO; i++) f[i*CFG_WIDTH +: CFG_WIDTH] = model_mem[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_GPIO; i++) model_mem[i] = INIT[i*CFG_WIDTH +: CFG_WIDTH];
    endtask

    // Expected per-cycle outputs of one full load, from the first SHIFT cycle.
    task automatic push_load(input logic ack0, input logic err0, input logic hold_ack, input logic hold_err);
        logic [VEC_W-1:0] v;
        for (int t = 0; t < SHIFT_CYC; t++) begin
            int k, ch, b;
            logic hi;
            k  = t / (2 * CLK_DIV);
            hi = ((t % (2 * CLK_DIV)) >= CLK_DIV);
            ch = NUM_GPIO - 1 - k / CFG_WIDTH;
            b  = CFG_WIDTH - 1 - k % CFG_WIDTH;
            v  = {1'b1, hi, model_mem[ch][b], 2'b00, (t == 0) ? ack0 : 1'b0, (t == 0) ? err0 : 1'b0};
            exp_q.push_back(v);
        end
        for (int t = 0; t < CLK_DIV; t++) exp_q.push_back(7'b1001000);
        exp_q.push_back(7'b0000100);                       // DONE
        exp_q.push_back(7'b0000000);                       // first IDLE cycle
        exp_q.push_back({5'b00000, hold_ack, hold_err});   // stalled write acked here
        exp_q.push_back(7'b0000000);
    endtask

    // ---------------- driver tasks ----------------
    // Checks one cycle per expected entry; optionally raises a held write at
    // hold_at, drops it at drop_at, and pulses start randomly before junk_until.
    task automatic play(input int hold_at, input int drop_at, input int junk_until, input int stop_after);
        int i;
        i = 0;
        while (exp_q.size() > 0) begin
            if (stop_after >= 0 && i == stop_after) break;
            check($sformatf("seq_cyc%0d", i), obs(), exp_q.pop_front());
            start = (i < junk_until) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == hold_at) ovr_we = 1'b1;
            if (i == drop_at) ovr_we = 1'b0;
            @(negedge clk);
            i++;
        end
        start = 1'b0;
    endtask

    task automatic start_load(input int junk_until);
        push_load(1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        play(-1, -1, junk_until, -1);
        check("defaults_after_load", gpio_defaults, model_flat());
    endtask

    task automatic idle_write(input int idx, input logic [CFG_WIDTH-1:0] data);
        logic bad;
        bad = (idx >= NUM_GPIO);
        ovr_we = 1'b1;
        ovr_idx = IDX_W'(idx);
        ovr_data = data;
        @(negedge clk);
        if (!bad) model_mem[idx] = data;
        check("ovr_ack", 32'(ovr_ack), 32'(1));
        check("ovr_err", 32'(ovr_err), 32'(bad));
        check("defaults_wr", gpio_defaults, model_flat());
        ovr_we = 1'b0;
        @(negedge clk);
        check("ack_clear", 32'({ovr_ack, ovr_err}), 32'(0));
    endtask

    task automatic write_with_start(input int idx, input logic [CFG_WIDTH-1:0] data);
        logic bad;
        bad = (idx >= NUM_GPIO);
        ovr_we = 1'b1;
        ovr_idx = IDX_W'(idx);
        ovr_data = data;
        start = 1'b1;
        if (!bad) model_mem[idx] = data;
        push_load(1'b1, bad, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        ovr_we = 1'b0;
        play(-1, -1, 0, -1);
        check("defaults_wr_start", gpio_defaults, model_flat());
    endtask

    task automatic held_write(input int idx, input logic [CFG_WIDTH-1:0] data);
        logic bad;
        bad = (idx >= NUM_GPIO);
        ovr_idx = IDX_W'(idx);
        ovr_data = data;
        push_load(1'b0, 1'b0, 1'b1, bad);   // stream uses the words before the write
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        play($urandom_range(1, SHIFT_CYC - 1), ACK_IDX, 0, -1);
        if (!bad) model_mem[idx] = data;
        check("defaults_held_wr", gpio_defaults, model_flat());
    endtask

    task automatic after_release();
`ifdef GPIO_DEFAULTS_AUTOLOAD_EN
        push_load(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        play(-1, -1, 0, -1);
`else
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_reset", obs(), '0);
        end
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        model_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", obs(), '0);
        check("reset_defaults", gpio_defaults, INIT);
        resetn = 1'b1;
        after_release();

        // Full load from the power-on words, with start pulsed while busy.
        start_load(SHIFT_CYC + CLK_DIV);

        // Directed overrides: valid write then out-of-range index.
        idle_write(0, 4'hF);
        idle_write(3, 4'h6);
        start_load(0);

        // Randomized mix of writes and loads.
        for (int iter = 0; iter < 8; iter++) begin
            int mode;
            idle_write($urandom_range(0, 3), CFG_WIDTH'($urandom_range(0, 15)));
            mode = $urandom_range(0, 2);
            case (mode)
                0: start_load($urandom_range(0, 1) ? SHIFT_CYC : 0);
                1: write_with_start($urandom_range(0, 3), CFG_WIDTH'($urandom_range(0, 15)));
                default: held_write($urandom_range(0, 3), CFG_WIDTH'($urandom_range(0, 15)));
            endcase
        end

        // Reset in the middle of bit 5: outputs drop at once, nothing latches.
        push_load(1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        play(-1, -1, 0, 5 * 2 * CLK_DIV + 1);
        exp_q.delete();
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", obs(), '0);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_hold_outputs", obs(), '0);
            check("reset_hold_defaults", gpio_defaults, INIT);
        end
        resetn = 1'b1;
        after_release();
        start_load(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
